uart_byte_rx: RTL and testbench

UART receiver that turns the serial `rx` line into one 8-bit byte per frame, with a one-cycle strobe per byte. It sits directly upstream of the instruction-memory loader. That loader counts strobes to assemble four bytes, MSB first, into each 32-bit instruction word. The block runs 16x oversampling with 3-sample majority voting, rejects false starts, and flags framing errors so corrupted bytes never reach instruction memory.

---
 rtl/uart_byte_rx_if.sv | 11 +
 rtl/uart_byte_rx.sv | 146 ++++++++++++++
 tb/tb_uart_byte_rx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_byte_rx_if.sv
// Byte-stream interface between the serial line and the UART receiver's consumer.
interface uart_byte_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (input rx, output data, output data_valid, output frame_err, output busy);
  modport slave  (output rx, input data, input data_valid, input frame_err, input busy);
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote per bit,
// false-start rejection and framing-error flagging.
module uart_byte_rx #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV        = (CLK_FREQ + BAUD * 8) / (BAUD * 16)
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  uart_byte_rx_if.master bus
);

  localparam int unsigned TICK_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SAMP_LAST = OVERSAMPLE - 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t              state_q, state_d;
  logic                rx_meta_q, rx_s_q;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]          samp_q, samp_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                s7_q, s7_d, s8_q, s8_d;
  logic [7:0]          data_q, data_d;
  logic                data_valid_q, data_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;
  logic                tick_c, vote_c, vote_tick_c, wrap_tick_c;

  // Two-flop synchronizer; idle-high so reset never looks like a start bit.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      samp_q       <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      s7_q         <= 1'b0;
      s8_q         <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      samp_q       <= samp_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      s7_q         <= s7_d;
      s8_q         <= s8_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // The tick leaving samp 8 is the one that lands on samp 9 (9*DIV into the
  // cell); rx_s at that tick is the third sample of the vote.
  assign tick_c      = (tick_cnt_q == TICK_W'(DIV - 1));
  assign vote_c      = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
  assign vote_tick_c = tick_c && (samp_q == 4'd8);
  assign wrap_tick_c = tick_c && (samp_q == 4'(SAMP_LAST));

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    samp_d       = samp_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    s7_d         = s7_q;
    s8_d         = s8_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q != IDLE) begin
      tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
      if (tick_c) begin
        samp_d = samp_q + 4'd1;
        if (samp_q == 4'd6) s7_d = rx_s_q;
        if (samp_q == 4'd7) s8_d = rx_s_q;
      end
    end

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        samp_d     = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (vote_tick_c && vote_c) begin
          state_d = IDLE;
        end else if (wrap_tick_c) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (vote_tick_c) shreg_d = {vote_c, shreg_q[7:1]};
        if (wrap_tick_c) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (vote_tick_c) begin
          if (vote_c) begin
            data_d       = shreg_q;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: serial frames in, byte stream and
// pulse properties compared against a queue-based reference model.
module tb_uart_byte_rx;

  localparam int BIT = 16 * 27;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_byte_rx_if u_if ();

  uart_byte_rx #(.CLK_FREQ(50_000_000), .BAUD(115200)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_start  = 0;

  // Monitor state
  logic [7:0] obs_q[$];
  int         obs_t[$];
  logic [7:0] exp_q[$];
  int         dv_cnt = 0, fe_cnt = 0, overlap = 0, wide = 0, unstable = 0;
  logic       dv_prev = 1'b0, fe_prev = 1'b0, rst_prev = 1'b1;
  logic [7:0] data_prev = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.data_valid) begin
      obs_q.push_back(u_if.data);
      obs_t.push_back(cyc);
    end
    dv_cnt <= dv_cnt + int'(u_if.data_valid);
    fe_cnt <= fe_cnt + int'(u_if.frame_err);
    if (u_if.data_valid && u_if.frame_err) overlap <= overlap + 1;
    if ((u_if.data_valid && dv_prev) || (u_if.frame_err && fe_prev)) wide <= wide + 1;
    if (!rst && !rst_prev && (u_if.data != data_prev) && !(u_if.data_valid && !dv_prev))
      unstable <= unstable + 1;
    dv_prev   <= u_if.data_valid;
    fe_prev   <= u_if.frame_err;
    data_prev <= u_if.data;
    rst_prev  <= rst;
  end

  task automatic cells(input logic v, input int n);
    u_if.rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transmit one 8N1 frame with the given cell length; model records good bytes.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int len);
    t_start = cyc;
    cells(1'b0, len);
    for (int i = 0; i < 8; i++) cells(b[i], len);
    cells(stop, len);
    if (stop) exp_q.push_back(b);
  endtask

  task automatic clear_model();
    obs_q.delete();
    obs_t.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    u_if.rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (u_if.data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", u_if.data); end
    n_checks++; if (u_if.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b want 0", u_if.data_valid); end
    n_checks++; if (u_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_fe got %b want 0", u_if.frame_err); end
    n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", u_if.busy); end
    begin
      int dv0 = dv_cnt, fe0 = fe_cnt, busy_hi = 0;
      for (int i = 0; i < 10000; i++) begin
        cells(1'b1, 1);
        if (u_if.busy !== 1'b0) busy_hi++;
      end
      n_checks++; if (dv_cnt - dv0 != 0) begin n_fail++; $display("FAIL idle_dv got %0d pulses want 0", dv_cnt - dv0); end
      n_checks++; if (fe_cnt - fe0 != 0) begin n_fail++; $display("FAIL idle_fe got %0d pulses want 0", fe_cnt - fe0); end
      n_checks++; if (busy_hi != 0) begin n_fail++; $display("FAIL idle_busy got %0d busy clocks want 0", busy_hi); end
    end
  endtask

  task automatic test_single();
    int fe0 = fe_cnt;
    int lat;
    clear_model();
    send_frame(8'hA5, 1'b1, BIT);
    cells(1'b1, 200);
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", obs_q.size()); end
    else begin
      lat = obs_t[0] - t_start;
      n_checks++; if (obs_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", obs_q[0]); end
      n_checks++; if (lat < 4130 || lat > 4136) begin n_fail++; $display("FAIL single_latency got %0d want 4133+-3", lat); end
    end
    n_checks++; if (u_if.data !== 8'hA5) begin n_fail++; $display("FAIL single_hold got %h want a5", u_if.data); end
    n_checks++; if (fe_cnt != fe0) begin n_fail++; $display("FAIL single_fe got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes[4];
    logic [31:0] word = 32'h0;
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
    clear_model();
    for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1, BIT);
    cells(1'b1, 300);
    n_checks++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", obs_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        word = {word[23:0], obs_q[i]};
      end
      n_checks++; if (word !== 32'h12345678) begin n_fail++; $display("FAIL b2b_word got %h want 12345678", word); end
    end
  endtask

  task automatic test_false_start();
    int dv0 = dv_cnt, fe0 = fe_cnt;
    cells(1'b0, 81);
    cells(1'b1, 270 - 81);
    n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0", u_if.busy); end
    cells(1'b1, 100);
    n_checks++; if (dv_cnt != dv0 || fe_cnt != fe0) begin n_fail++; $display("FAIL glitch_pulse got dv=%0d fe=%0d want 0 0", dv_cnt - dv0, fe_cnt - fe0); end
    clear_model();
    send_frame(8'h3C, 1'b1, BIT);
    cells(1'b1, 300);
    n_checks++; if (obs_q.size() != 1 || obs_q[0] !== 8'h3C) begin n_fail++; $display("FAIL glitch_next got n=%0d d=%h want 1 3c", obs_q.size(), u_if.data); end
  endtask

  task automatic test_frame_err();
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    clear_model();
    send_frame(8'hFF, 1'b0, BIT);
    cells(1'b0, 2 * BIT);
    n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL ferr_count got %0d want 1", fe_cnt - fe0); end
    n_checks++; if (dv_cnt != dv0) begin n_fail++; $display("FAIL ferr_dv got %0d want 0", dv_cnt - dv0); end
    n_checks++; if (u_if.data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data got %h want 3c", u_if.data); end
    n_checks++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_busy got %b want 1", u_if.busy); end
    cells(1'b1, 50);
    n_checks++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release_busy got %b want 0", u_if.busy); end
    send_frame(8'h81, 1'b1, BIT);
    cells(1'b1, 300);
    n_checks++; if (obs_q.size() != 1 || u_if.data !== 8'h81) begin n_fail++; $display("FAIL ferr_next got n=%0d d=%h want 1 81", obs_q.size(), u_if.data); end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] b = 8'hC3;
    int dv0, fe0;
    clear_model();
    cells(1'b0, BIT);
    for (int i = 0; i < 4; i++) cells(b[i], BIT);
    cells(b[4], BIT / 2);
    rst = 1'b1;
    #1;
    n_checks++; if (u_if.data !== 8'h00) begin n_fail++; $display("FAIL mrst_data got %h want 00", u_if.data); end
    n_checks++; if (u_if.busy !== 1'b0 || u_if.data_valid !== 1'b0 || u_if.frame_err !== 1'b0)
      begin n_fail++; $display("FAIL mrst_flags got busy=%b dv=%b fe=%b want 0 0 0", u_if.busy, u_if.data_valid, u_if.frame_err); end
    u_if.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    cells(1'b1, 1000);
    n_checks++; if (dv_cnt != dv0 || fe_cnt != fe0) begin n_fail++; $display("FAIL mrst_pulse got dv=%0d fe=%0d want 0 0", dv_cnt - dv0, fe_cnt - fe0); end
    send_frame(8'h5A, 1'b1, BIT);
    cells(1'b1, 300);
    n_checks++; if (obs_q.size() != 1 || u_if.data !== 8'h5A) begin n_fail++; $display("FAIL mrst_next got n=%0d d=%h want 1 5a", obs_q.size(), u_if.data); end
  endtask

  // Random bytes with up to +-3% transmitter rate error and random idle gaps.
  task automatic test_random();
    clear_model();
    for (int k = 0; k < 5; k++) begin
      logic [7:0] b = 8'($urandom_range(0, 255));
      int len = BIT - 13 + int'($urandom_range(0, 26));
      send_frame(b, 1'b1, len);
      cells(1'b1, int'($urandom_range(0, 40)));
    end
    cells(1'b1, 300);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_invariants();
    n_checks++; if (overlap != 0) begin n_fail++; $display("FAIL excl_overlap got %0d want 0", overlap); end
    n_checks++; if (wide != 0) begin n_fail++; $display("FAIL pulse_width got %0d long pulses want 0", wide); end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL data_stable got %0d changes want 0", unstable); end
  endtask

  initial begin
    u_if.rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_midframe_reset();
    test_random();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
